// File: rtl/blinky_multi.sv
// Multi-channel LED pattern generator: per-channel off/on/blink/breathe driven by a shared
// prescaler, PWM counter, triangle ramp and blink phase; odd channels run in antiphase.
module blinky_multi #(
    parameter int CHANNELS    = 2,
    parameter int PRESCALE    = 12000,
    parameter int PWM_BITS    = 4,
    parameter int BLINK_TICKS = 50
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [2*CHANNELS-1:0] mode,
    output logic [CHANNELS-1:0]   led,
    output logic                  tick
);

    // Ramp direction states
    //   state     | meaning
    //   RAMP_UP   | level climbs by one per tick until it reaches MAX
    //   RAMP_DOWN | level falls by one per tick until it reaches 0
    typedef enum logic {RAMP_UP, RAMP_DOWN} dir_t;

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BLK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PWM_BITS-1:0] MAX       = '1;
    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [BLK_W-1:0]    BLK_LAST  = BLK_W'(BLINK_TICKS - 1);

    logic [PRE_W-1:0]    pre_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] level_next;
    logic [PWM_BITS-1:0] lvl;
    logic [BLK_W-1:0]    blink_cnt;
    logic                phase;
    logic                wrap;
    logic [CHANNELS-1:0] led_next;
    dir_t                dir;
    dir_t                dir_next;

    assign wrap = en && (pre_cnt == PRE_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt   <= '0;
            pwm_cnt   <= '0;
            level     <= '0;
            dir       <= RAMP_UP;
            blink_cnt <= '0;
            phase     <= 1'b0;
            led       <= '0;
            tick      <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            tick    <= wrap;
            led     <= led_next;
            level   <= level_next;
            dir     <= dir_next;
            if (en) begin
                pre_cnt <= wrap ? '0 : pre_cnt + 1'b1;
            end
            if (wrap) begin
                if (blink_cnt == BLK_LAST) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

    // Direction flips on the same tick that the level lands on an end point.
    always_comb begin
        dir_next = dir;
        if (wrap) begin
            if (dir == RAMP_UP && level_next == MAX) begin
                dir_next = RAMP_DOWN;
            end else if (dir == RAMP_DOWN && level_next == '0) begin
                dir_next = RAMP_UP;
            end
        end
    end

    always_comb begin
        level_next = level;
        if (wrap) begin
            level_next = (dir == RAMP_UP) ? level + 1'b1 : level - 1'b1;
        end
    end

    always_comb begin
        led_next = '0;
        lvl      = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            lvl = (i % 2 == 0) ? level : MAX - level;
            case (mode[2*i +: 2])
                2'b00:   led_next[i] = 1'b0;
                2'b01:   led_next[i] = 1'b1;
                2'b10:   led_next[i] = (i % 2 == 0) ? phase : ~phase;
                default: led_next[i] = (pwm_cnt < lvl);
            endcase
        end
    end

endmodule

// File: tb/tb_blinky_multi.sv
// Directed bench for blinky_multi with CHANNELS=2, PRESCALE=4, PWM_BITS=3, BLINK_TICKS=2.
module tb_blinky_multi;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       en    = 1'b0;
    logic [3:0] mode  = 4'b0000;
    logic [1:0] led;
    logic       tick;

    int checks = 0;
    int errors = 0;

    blinky_multi #(
        .CHANNELS(2),
        .PRESCALE(4),
        .PWM_BITS(3),
        .BLINK_TICKS(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .mode(mode),
        .led(led),
        .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n, input logic [3:0] m, input logic e);
        rst_n = 1'b0;
        mode  = m;
        en    = e;
        repeat (n) edge_wait();
        rst_n = 1'b1;
    endtask

    // Triangle level after t ticks: 0..7 up, then 6..0 down, period 14.
    function automatic int tri_level(input int t);
        int r;
        r = t % 14;
        return (r <= 7) ? r : 14 - r;
    endfunction

    function automatic logic [1:0] breathe_exp(input int pwm, input int lvl);
        logic [1:0] r;
        r[0] = (pwm < lvl);
        r[1] = (pwm < (7 - lvl));
        return r;
    endfunction

    task automatic test_reset();
        logic exp_tick;
        rst_n = 1'b0;
        mode  = 4'b0000;
        en    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            edge_wait();
            checks++;
            if (led !== 2'b00 || tick !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: led=%b tick=%b, required led=00 tick=0", i, led, tick);
            end
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            edge_wait();
            exp_tick = (k % 4 == 0);
            checks++;
            if (tick !== exp_tick || led !== 2'b00) begin
                errors++;
                $display("FAIL tick_timing edge %0d: tick=%b led=%b, required tick=%b led=00", k, tick, led, exp_tick);
            end
        end
    endtask

    task automatic test_on_mode();
        do_reset(3, 4'b0000, 1'b1);
        edge_wait();
        edge_wait();
        mode = 4'b0001;
        edge_wait();
        checks++;
        if (led !== 2'b01) begin errors++; $display("FAIL on_rise: led=%b, required 01", led); end
        edge_wait();
        checks++;
        if (led !== 2'b01) begin errors++; $display("FAIL on_hold: led=%b, required 01", led); end
        mode = 4'b0000;
        edge_wait();
        checks++;
        if (led !== 2'b00) begin errors++; $display("FAIL on_fall: led=%b, required 00", led); end
        mode = 4'b0100;
        edge_wait();
        checks++;
        if (led !== 2'b10) begin errors++; $display("FAIL on_ch1: led=%b, required 10", led); end
        mode = 4'b0001;
        edge_wait();
        checks++;
        if (led !== 2'b01) begin errors++; $display("FAIL on_swap: led=%b, required 01", led); end
        mode = 4'b0101;
        edge_wait();
        checks++;
        if (led !== 2'b11) begin errors++; $display("FAIL on_both: led=%b, required 11", led); end
    endtask

    task automatic test_blink();
        int p;
        logic [1:0] exp_led;
        do_reset(3, 4'b1010, 1'b1);
        for (int k = 1; k <= 40; k++) begin
            edge_wait();
            p = ((k - 1) / 8) % 2;
            exp_led = (p == 1) ? 2'b01 : 2'b10;
            checks++;
            if (led !== exp_led) begin
                errors++;
                $display("FAIL blink edge %0d: led=%b, required %b", k, led, exp_led);
            end
        end
    endtask

    task automatic test_breathe();
        logic [1:0] exp_led;
        logic       exp_tick;
        do_reset(3, 4'b1111, 1'b1);
        for (int k = 1; k <= 64; k++) begin
            edge_wait();
            exp_led  = breathe_exp((k - 1) % 8, tri_level((k - 1) / 4));
            exp_tick = (k % 4 == 0);
            checks++;
            if (led !== exp_led || tick !== exp_tick) begin
                errors++;
                $display("FAIL breathe edge %0d: led=%b tick=%b, required led=%b tick=%b",
                         k, led, tick, exp_led, exp_tick);
            end
        end
    endtask

    // ch0 breathes and ch1 blinks, so both the ramp level and the blink phase are visible.
    task automatic test_freeze();
        int         active;
        logic       en_now;
        logic [1:0] exp_led;
        logic       exp_tick;
        int         ph;
        active = 0;
        do_reset(3, 4'b1011, 1'b1);
        for (int k = 1; k <= 70; k++) begin
            if (k == 23) en = 1'b0;
            if (k == 43) en = 1'b1;
            en_now = en;
            edge_wait();
            ph          = ((active / 4) / 2) % 2;
            exp_led[0]  = (((k - 1) % 8) < tri_level(active / 4));
            exp_led[1]  = (ph == 0);
            exp_tick    = en_now && (((active + 1) % 4) == 0);
            if (en_now) active++;
            checks++;
            if (led !== exp_led || tick !== exp_tick) begin
                errors++;
                $display("FAIL freeze edge %0d en=%b: led=%b tick=%b, required led=%b tick=%b",
                         k, en_now, led, tick, exp_led, exp_tick);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] exp_led;
        logic       exp_tick;
        do_reset(3, 4'b1111, 1'b1);
        for (int k = 1; k <= 21; k++) begin
            edge_wait();
            exp_led = breathe_exp((k - 1) % 8, tri_level((k - 1) / 4));
            checks++;
            if (led !== exp_led) begin
                errors++;
                $display("FAIL pre_reset edge %0d: led=%b, required %b", k, led, exp_led);
            end
        end
        rst_n = 1'b0;
        edge_wait();
        checks++;
        if (led !== 2'b00 || tick !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: led=%b tick=%b, required led=00 tick=0", led, tick);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            edge_wait();
            exp_led  = breathe_exp((k - 1) % 8, tri_level((k - 1) / 4));
            exp_tick = (k % 4 == 0);
            checks++;
            if (led !== exp_led || tick !== exp_tick) begin
                errors++;
                $display("FAIL post_reset edge %0d: led=%b tick=%b, required led=%b tick=%b",
                         k, led, tick, exp_led, exp_tick);
            end
        end
    endtask

    initial begin
        test_reset();
        test_on_mode();
        test_blink();
        test_breathe();
        test_freeze();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
